// File: rtl/div_unit_pkg.sv
// Shared state codes and flag values for the multi-cycle divider.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not go negative.
module div_sub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_next_rem,
    output logic             o_quo_bit
);

    logic [WIDTH-1:0] w_diff;

    // The true difference is smaller than the divisor whenever it is kept,
    // so the low WIDTH bits of a wrapping subtract are exact.
    assign w_diff     = i_rem[WIDTH-1:0] - i_divisor;
    assign o_quo_bit  = (i_rem >= {1'b0, i_divisor});
    assign o_next_rem = o_quo_bit ? w_diff : i_rem[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU beside the execute stage.
// result_o = {remainder, quotient}, valid while ready_o is high.
// Handshake: the requester raises start_i with operands and holds it until it
// sees ready_o; the result stays presented until start_i drops (or annul_i),
// and the edge that sees start_i low clears ready_o and result_o.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_e         r_state;
    div_state_e         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_quo_neg;
    logic               r_rem_neg;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic               w_req;
    logic               w_last;
    logic [WIDTH-1:0]   w_next_rem;
    logic               w_quo_bit;
    logic [WIDTH-1:0]   w_next_quo;
    logic [WIDTH-1:0]   w_fix_quo;
    logic [WIDTH-1:0]   w_fix_rem;

    // Operand magnitudes and signs; only meaningful on the FREE->ON edge.
    assign w_a_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign w_b_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign w_a_abs = w_a_neg ? -opdata1_i : opdata1_i;
    assign w_b_abs = w_b_neg ? -opdata2_i : opdata2_i;

    assign w_req  = (start_i == DIV_START) && !annul_i;
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // The step sees the remainder shifted left with the next dividend bit.
    div_sub_step #(.WIDTH(WIDTH)) u_step (
        .i_rem      ({r_rem, r_quo[WIDTH-1]}),
        .i_divisor  (r_divisor),
        .o_next_rem (w_next_rem),
        .o_quo_bit  (w_quo_bit)
    );

    assign w_next_quo = {r_quo[WIDTH-2:0], w_quo_bit};
    assign w_fix_quo  = r_quo_neg ? -w_next_quo : w_next_quo;
    assign w_fix_rem  = r_rem_neg ? -w_next_rem : w_next_rem;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= DIV_FREE;
        else      r_state <= w_next_state;
    end

    // Next-state decode; annul wins over stepping and completion.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DIV_FREE: begin
                if (w_req) w_next_state = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
            end
            DIV_BY_ZERO: w_next_state = DIV_END;
            DIV_ON: begin
                if (annul_i)     w_next_state = DIV_FREE;
                else if (w_last) w_next_state = DIV_END;
            end
            DIV_END: begin
                if (start_i == DIV_STOP || annul_i) w_next_state = DIV_FREE;
            end
            default: w_next_state = DIV_FREE;
        endcase
    end

    // Datapath: latch operands, iterate, sign-fix and present the result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_quo_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_result  <= '0;
            r_ready   <= DIV_RESULT_NOT_READY;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    r_result <= '0;
                    r_ready  <= DIV_RESULT_NOT_READY;
                    if (w_req && opdata2_i != '0) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_a_abs;
                        r_divisor <= w_b_abs;
                        r_quo_neg <= w_a_neg ^ w_b_neg;
                        r_rem_neg <= w_a_neg;
                    end
                end
                DIV_BY_ZERO: begin
                    r_result <= '0;
                    r_ready  <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (!annul_i) begin
                        r_rem <= w_next_rem;
                        r_quo <= w_next_quo;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_result <= {w_fix_rem, w_fix_quo};
                            r_ready  <= DIV_RESULT_READY;
                        end
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP || annul_i) begin
                        r_result <= '0;
                        r_ready  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: begin
                    r_result <= '0;
                    r_ready  <= DIV_RESULT_NOT_READY;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, annul, mid-operation reset and held-request behaviour.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_pass  = 0;
    int n_total = 0;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request, count edges to ready_o (bounded), check latency and
    // result, then drop the request and check the outputs clear.
    task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
        int edges;
        signed_div_i = sd;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        edges        = 0;
        do begin
            tick();
            edges++;
            if (edges == 1) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
        end while (!ready_o && edges < 200);
        chk({tag, "_lat"}, 64'(edges), 64'(exp_lat));
        chk({tag, "_res"}, result_o, exp_res);
        start_i = 1'b0;
        tick();
        chk({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
        chk({tag, "_drop_res"}, result_o, 64'd0);
    endtask

    initial begin
        int   edges;
        logic saw_ready;
        logic [63:0] held;

        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        tick();
        tick();
        chk("reset_rdy", 64'(ready_o), 64'd0);
        chk("reset_res", result_o, 64'd0);
        rst = 1'b1;
        tick();
        chk("idle_rdy", 64'(ready_o), 64'd0);

        run_div("divu_100_7",   1'b0, 32'd100,        32'd7,          33, 64'h00000002_0000000E);
        run_div("div_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          33, 64'hFFFFFFFF_FFFFFFFD);
        run_div("div_7_m2",     1'b1, 32'd7,          32'hFFFFFFFE,   33, 64'h00000001_FFFFFFFD);
        run_div("div_ovf",      1'b1, 32'h80000000,   32'hFFFFFFFF,   33, 64'h00000000_80000000);
        run_div("divu_big",     1'b0, 32'hFFFFFFFF,   32'd1,          33, 64'h00000000_FFFFFFFF);
        run_div("divu_5_0",     1'b0, 32'd5,          32'd0,          2,  64'd0);

        // Annul on the 10th ON cycle: edge 1 starts, edges 2..10 step,
        // annul is applied at edge 11.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        saw_ready    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_ready |= ready_o;
        end
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        saw_ready |= ready_o;
        chk("annul_rdy", 64'(ready_o), 64'd0);
        chk("annul_res", result_o, 64'd0);
        annul_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            saw_ready |= ready_o;
        end
        chk("annul_never_ready", 64'(saw_ready), 64'd0);
        run_div("after_annul",  1'b0, 32'hFFFFFFFF,   32'h10,         33, 64'h0000000F_0FFFFFFF);

        // Reset mid-ON with the request held throughout.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b0;
        tick();
        chk("midrst_rdy", 64'(ready_o), 64'd0);
        chk("midrst_res", result_o, 64'd0);
        rst   = 1'b1;
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!ready_o && edges < 200);
        chk("midrst_lat", 64'(edges), 64'd33);
        chk("midrst_res2", result_o, 64'h00000002_0000000E);
        held = result_o;
        for (int i = 0; i < 5; i++) begin
            opdata1_i = $urandom_range(1, 1000);
            opdata2_i = $urandom_range(1, 1000);
            tick();
            chk($sformatf("hold_rdy_%0d", i), 64'(ready_o), 64'd1);
            chk($sformatf("hold_res_%0d", i), result_o, held);
        end
        start_i = 1'b0;
        tick();
        chk("hold_drop_rdy", 64'(ready_o), 64'd0);
        chk("hold_drop_res", result_o, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
